// File: rtl/game_pkg.sv
// Shared constants and state encoding for the guessing-game sequencer.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIVES_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_WELCOME = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_LOSE    = 3'd3,
    S_WIN     = 3'd4
  } state_t;

endpackage

// File: rtl/game_timer.sv
// Per-round countdown: loadable, decrements on tick while running, saturates at 0.
module game_timer #(
  parameter int unsigned TIME_W  = 5,
  parameter int unsigned RST_VAL = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              run,
  input  logic              tick,
  output logic [TIME_W-1:0] value,
  output logic              zero_evt
);

  // Flags the edge on which the count goes 1 -> 0 so the controller can act on it at once.
  assign zero_evt = run && tick && (value == TIME_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= TIME_W'(RST_VAL);
    end else if (load) begin
      value <= load_val;
    end else if (run && tick && (value != '0)) begin
      value <= value - TIME_W'(1);
    end
  end

endmodule

// File: rtl/game_control.sv
// Game sequencer: welcome/ready/play/lose/win flow, level and lives tracking, round-time loading.
module game_control
  import game_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned TIME_W     = 5,
  parameter int unsigned START_TIME = 30,
  parameter int unsigned TIME_STEP  = 2,
  parameter int unsigned MIN_TIME   = 3,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MAX_LEVEL  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               guess_b,
  input  logic               cmp_r,
  input  logic               tick,
  output logic [STATE_W-1:0] state,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  time_v,
  output logic               time_f,
  output logic               g_enable,
  output logic               g_load,
  output logic [LIVES_W-1:0] lives
);

  localparam int unsigned CALC_W = LEVEL_W + TIME_W + 2;

  state_t              state_q;
  logic                timer_load;
  logic                timer_run;
  logic                zero_evt;
  logic [TIME_W-1:0]   load_val;
  logic signed [CALC_W-1:0] start_s, step_s, min_s, lvl_s, diff_s;

  // Round time shrinks with level; signed math lets a negative result clamp to the floor.
  assign start_s  = $signed(CALC_W'(START_TIME));
  assign step_s   = $signed(CALC_W'(TIME_STEP));
  assign min_s    = $signed(CALC_W'(MIN_TIME));
  assign lvl_s    = $signed(CALC_W'(level));
  assign diff_s   = start_s - step_s * lvl_s;
  assign load_val = (diff_s < min_s) ? TIME_W'(MIN_TIME) : TIME_W'(diff_s);

  assign timer_load = (state_q == S_READY) && guess_b;
  assign timer_run  = (state_q == S_PLAY);
  assign state      = state_q;

  game_timer #(
    .TIME_W  (TIME_W),
    .RST_VAL (START_TIME)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (load_val),
    .run      (timer_run),
    .tick     (tick),
    .value    (time_v),
    .zero_evt (zero_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WELCOME;
      level    <= '0;
      time_f   <= 1'b0;
      g_enable <= 1'b0;
      g_load   <= 1'b0;
      lives    <= LIVES_W'(LIVES);
    end else begin
      g_load <= 1'b0;
      case (state_q)
        S_WELCOME: begin
          if (guess_b) state_q <= S_READY;
        end
        S_READY: begin
          if (guess_b) begin
            state_q  <= S_PLAY;
            time_f   <= 1'b1;
            g_enable <= 1'b1;
            g_load   <= 1'b1;
          end
        end
        S_PLAY: begin
          // A guess landing on the final tick takes priority over the timeout.
          if (guess_b && cmp_r) begin
            level   <= level + LEVEL_W'(1);
            time_f  <= 1'b0;
            state_q <= (level == LEVEL_W'(MAX_LEVEL - 1)) ? S_WIN : S_READY;
          end else if (guess_b || zero_evt) begin
            time_f <= 1'b0;
            if (lives == LIVES_W'(1)) begin
              lives   <= '0;
              state_q <= S_LOSE;
            end else begin
              lives   <= lives - LIVES_W'(1);
              state_q <= S_READY;
            end
          end
        end
        S_LOSE: begin
          if (guess_b) begin
            state_q  <= S_READY;
            level    <= '0;
            lives    <= LIVES_W'(LIVES);
            g_enable <= 1'b0;
          end
        end
        S_WIN: begin
          if (guess_b) begin
            state_q  <= S_WELCOME;
            level    <= '0;
            lives    <= LIVES_W'(LIVES);
            g_enable <= 1'b0;
          end
        end
        default: state_q <= S_WELCOME;
      endcase
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: a vector table for the basic flow plus hand-written multi-cycle sequences.
module tb_game_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       guess_b;
  logic       cmp_r;
  logic       tick;
  logic [2:0] state;
  logic [7:0] level;
  logic [4:0] time_v;
  logic       time_f;
  logic       g_enable;
  logic       g_load;
  logic [2:0] lives;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic g;
    logic c;
    logic t;
    int   st;
    int   lv;
    int   tv;
    int   tf;
    int   ge;
    int   gl;
    int   li;
  } vec_t;

  vec_t vecs[10];

  game_control dut (
    .clk      (clk),
    .rst      (rst),
    .guess_b  (guess_b),
    .cmp_r    (cmp_r),
    .tick     (tick),
    .state    (state),
    .level    (level),
    .time_v   (time_v),
    .time_f   (time_f),
    .g_enable (g_enable),
    .g_load   (g_load),
    .lives    (lives)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int lv, input int tv,
                           input int tf, input int ge, input int gl, input int li);
    check({tag, ".state"},    int'(state),    st);
    check({tag, ".level"},    int'(level),    lv);
    check({tag, ".time_v"},   int'(time_v),   tv);
    check({tag, ".time_f"},   int'(time_f),   tf);
    check({tag, ".g_enable"}, int'(g_enable), ge);
    check({tag, ".g_load"},   int'(g_load),   gl);
    check({tag, ".lives"},    int'(lives),    li);
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic g, input logic c, input logic t);
    guess_b = g;
    cmp_r   = c;
    tick    = t;
    @(posedge clk);
    #1;
    guess_b = 1'b0;
    cmp_r   = 1'b0;
    tick    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; guess_b = 1'b0; cmp_r = 1'b0; tick = 1'b0;
    #1;

    // inputs g,c,t ; expected state, level, time_v, time_f, g_enable, g_load, lives
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 0, 30, 0, 0, 0, 3};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2, 0, 30, 1, 1, 1, 3};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 2, 0, 30, 1, 1, 0, 3};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2, 0, 29, 1, 1, 0, 3};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1, 0, 29, 0, 1, 0, 2};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1, 0, 29, 0, 1, 0, 2};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 2, 0, 30, 1, 1, 1, 2};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1, 1, 30, 0, 1, 0, 2};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 2, 1, 28, 1, 1, 1, 2};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1, 2, 28, 0, 1, 0, 2};

    do_reset();
    check_all("reset", 0, 0, 30, 0, 0, 0, 3);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].g, vecs[i].c, vecs[i].t);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].tv,
                vecs[i].tf, vecs[i].ge, vecs[i].gl, vecs[i].li);
    end

    // Timeout at level 2 (26 ticks), then a second timeout with the last life.
    step(1'b1, 1'b0, 1'b0);
    check("to1.load", int'(time_v), 26);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);
    check_all("to1.pre", 2, 2, 1, 1, 1, 0, 2);
    step(1'b0, 1'b0, 1'b1);
    check_all("to1.post", 1, 2, 0, 0, 1, 0, 1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) step(1'b0, 1'b0, 1'b1);
    check_all("to2.lose", 3, 2, 0, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    check("lose.tick_hold", int'(time_v), 0);
    step(1'b1, 1'b0, 1'b0);
    check_all("lose.exit", 1, 0, 0, 0, 0, 0, 3);

    // Correct guess on the same edge as the final tick: guess wins, no life lost.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 1'b1);
    check("race.pre", int'(time_v), 1);
    step(1'b1, 1'b1, 1'b1);
    check("race.state", int'(state), 1);
    check("race.level", int'(level), 1);
    check("race.lives", int'(lives), 3);
    check("race.time_f", int'(time_f), 0);

    // Climb to level 14; round time clamps to the floor, next correct guess wins.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check_all("lvl14", 1, 14, 4, 0, 1, 0, 3);
    step(1'b1, 1'b0, 1'b0);
    check_all("clamp", 2, 14, 3, 1, 1, 1, 3);
    step(1'b1, 1'b1, 1'b0);
    check_all("win", 4, 15, 3, 0, 1, 0, 3);
    step(1'b0, 1'b0, 1'b1);
    check("win.hold", int'(state), 4);
    step(1'b1, 1'b0, 1'b0);
    check_all("win.exit", 0, 0, 3, 0, 0, 0, 3);

    // Synchronous reset mid-round overrides a simultaneous guess.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1);
    check("rst.pre", int'(time_v), 12);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check_all("rst.mid", 0, 0, 30, 0, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
